// File: rtl/lut_reverse_search.sv
// Reverse lookup over a writable 8-entry table: scans one entry per clock and reports the lowest matching index.
// Latency 1..DEPTH cycles from accepted start to the done pulse; start is ignored while busy, with no queueing.
module lut_reverse_search #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [DW-1:0] key,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] index
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] key_r;
  logic [DW-1:0] tbl [DEPTH];

  // Power-on contents of the CPU constant/branch-target table.
  function automatic logic [DW-1:0] dflt(input int i);
    case (i)
      0:       dflt = DW'(8'h8E);
      1:       dflt = DW'(8'h6D);
      2:       dflt = DW'(8'h5B);
      3:       dflt = DW'(8'h05);
      4:       dflt = DW'(8'h17);
      5:       dflt = DW'(8'h01);
      default: dflt = '0;
    endcase
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
      key_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
      index <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= dflt(i);
    end else begin
      // The scan below reads tbl before this write lands, so a same-cycle compare sees the old value.
      if (wr_en) tbl[wr_addr] <= wr_data;

      case (state)
        IDLE: begin
          if (start) begin
            key_r <= key;
            ptr   <= '0;
            found <= 1'b0;
            index <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (tbl[ptr] == key_r) begin
            found <= 1'b1;
            index <= ptr;
            done  <= 1'b1;
            state <= DONE;
          end else if (ptr == AW'(DEPTH - 1)) begin
            found <= 1'b0;
            index <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_reverse_search.sv
// Directed bench for lut_reverse_search: driver pushes expected results, a monitor checks each done pulse.
module tb_lut_reverse_search;

  logic       Clk;
  logic       Reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [7:0] key;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] index;

  lut_reverse_search #(.DEPTH(8), .AW(3), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .key(key), .busy(busy), .done(done), .found(found), .index(index)
  );

  typedef struct {
    logic       f;
    logic [2:0] i;
    int         lat;
    logic [7:0] k;
  } exp_t;

  exp_t sbq[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   start_cyc  = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("found key=%02h", e.k), int'(found), int'(e.f));
        chk($sformatf("index key=%02h", e.k), int'(index), int'(e.i));
        chk($sformatf("latency key=%02h", e.k), cyc - start_cyc, e.lat);
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge E0.
  task automatic issue(input logic [7:0] k, input bit push, input logic f, input logic [2:0] i, input int lat);
    exp_t e;
    if (push) begin
      e.f = f; e.i = i; e.lat = lat; e.k = k;
      sbq.push_back(e);
    end
    start = 1'b1;
    key   = k;
    @(posedge Clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    @(negedge Clk);
    chk("busy_after_start", int'(busy), 1);
  endtask

  // Waits (bounded) for done, then checks that busy drops on the following edge.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge Clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_single_pulse", int'(done), 0);
  endtask

  task automatic search(input logic [7:0] k, input logic f, input logic [2:0] i, input int lat);
    issue(k, 1'b1, f, i, lat);
    wait_done();
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge Clk);
    #1;
    wr_en = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; key = '0;
    repeat (3) @(negedge Clk);
    chk("reset_busy",  int'(busy),  0);
    chk("reset_done",  int'(done),  0);
    chk("reset_found", int'(found), 0);
    chk("reset_index", int'(index), 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Default table lookups: hit, lowest duplicate, first entry, miss.
    search(8'h05, 1'b1, 3'd3, 4);
    search(8'h00, 1'b1, 3'd6, 7);
    search(8'h8E, 1'b1, 3'd0, 1);
    search(8'hFF, 1'b0, 3'd0, 8);

    // Overwrite entry 2 so 0x05 now hits earlier.
    write(3'd2, 8'h05);
    search(8'h05, 1'b1, 3'd2, 3);

    // Write entry 7 while the scan for the same value is in progress.
    issue(8'hAA, 1'b1, 1'b1, 3'd7, 8);
    @(negedge Clk);
    write(3'd7, 8'hAA);
    wait_done();

    // A start pulse while busy is dropped.
    issue(8'h17, 1'b1, 1'b1, 3'd4, 5);
    start = 1'b1;
    key   = 8'h01;
    @(posedge Clk);
    #1;
    start = 1'b0;
    @(negedge Clk);
    wait_done();
    repeat (3) @(negedge Clk);
    chk("hold_found", int'(found), 1);
    chk("hold_index", int'(index), 4);
    chk("no_extra_done", int'(done), 0);

    // Asynchronous reset in the middle of a scan.
    issue(8'hFF, 1'b0, 1'b0, 3'd0, 0);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("midreset_busy",  int'(busy),  0);
    chk("midreset_done",  int'(done),  0);
    chk("midreset_found", int'(found), 0);
    chk("midreset_index", int'(index), 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Table defaults restored: entry 2 back to 0x5B, entry 7 back to 0x00.
    search(8'h17, 1'b1, 3'd4, 5);
    search(8'h5B, 1'b1, 3'd2, 3);
    search(8'hAA, 1'b0, 3'd0, 8);

    repeat (4) @(negedge Clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
